// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with pointer/flag control, occupancy count and sticky errors.
// FWFT=0 gives a registered read; FWFT=1 keeps the head word presented on read_data.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_ena,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_full,
  input  logic                  read_ena,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  read_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] wr_ptr_reg, rd_ptr_reg, count_reg, count_next;
  logic          full_reg, afull_reg, aempty_reg, ovf_reg, unf_reg;
  logic          wr_acc, rd_take, rd_adv, arr_ne;

  assign wr_acc = write_ena && !full_reg;
  assign arr_ne = (wr_ptr_reg != rd_ptr_reg);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= write_data;
  end

  // rd_take is the event that removes an entry from the count (read or pop)
  always_comb begin
    count_next = count_reg;
    if (wr_acc && !rd_take)
      count_next = count_reg + ONE;
    else if (!wr_acc && rd_take)
      count_next = count_reg - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + ONE;
      if (rd_adv) rd_ptr_reg <= rd_ptr_reg + ONE;
      count_reg  <= count_next;
      full_reg   <= (count_next == FULL_CNT);
      afull_reg  <= (count_next >= AFULL_CNT);
      aempty_reg <= (count_next <= AEMPTY_CNT);
      if (write_ena && full_reg) ovf_reg <= 1'b1;
      if (read_ena && read_empty) unf_reg <= 1'b1;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  valid_reg, empty_reg;

      // pointer compare is redundant with the count but keeps the array read self-guarded
      assign rd_take = read_ena && !empty_reg && arr_ne;
      assign rd_adv  = rd_take;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
          empty_reg <= 1'b1;
        end else begin
          valid_reg <= rd_take;
          empty_reg <= (count_next == '0);
          if (rd_take) data_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        end
      end

      assign read_data  = data_reg;
      assign read_valid = valid_reg;
      assign read_empty = empty_reg;
    end else begin : g_fwft
      logic [DATA_WIDTH-1:0] s1_data_reg, out_data_reg;
      logic                  s1_valid_reg, out_valid_reg;
      logic                  pop, out_ready, s1_move, ram_rd;

      // Two stages: s1 captures the synchronous array read, out presents the head.
      assign pop       = read_ena && out_valid_reg;
      assign out_ready = !out_valid_reg || pop;
      assign s1_move   = s1_valid_reg && out_ready;
      assign ram_rd    = arr_ne && (!s1_valid_reg || s1_move);
      assign rd_take   = pop;
      assign rd_adv    = ram_rd;

      always_ff @(posedge clk) begin
        if (ram_rd) s1_data_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          out_data_reg  <= '0;
        end else begin
          if (ram_rd)
            s1_valid_reg <= 1'b1;
          else if (s1_move)
            s1_valid_reg <= 1'b0;
          if (s1_move) begin
            out_data_reg  <= s1_data_reg;
            out_valid_reg <= 1'b1;
          end else if (pop) begin
            out_valid_reg <= 1'b0;
          end
        end
      end

      assign read_data  = out_data_reg;
      assign read_valid = out_valid_reg;
      assign read_empty = !out_valid_reg;
    end
  endgenerate

  assign write_full   = full_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign count        = count_reg;
  assign overflow     = ovf_reg;
  assign underflow    = unf_reg;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: table-driven standard-mode vectors with a data scoreboard,
// plus hand-written FWFT and mid-operation reset sequences.
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance
  logic       s_rst, s_we, s_re;
  logic [7:0] s_wd, s_rdata;
  logic       s_full, s_rv, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [2:0] s_count;

  // FWFT instance
  logic       f_rst, f_we, f_re;
  logic [7:0] f_wd, f_rdata;
  logic       f_full, f_rv, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_count;

  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AFULL_LVL(3), .AEMPTY_LVL(1)) u_std (
    .clk(clk), .rst(s_rst), .write_ena(s_we), .write_data(s_wd), .write_full(s_full),
    .read_ena(s_re), .read_data(s_rdata), .read_valid(s_rv), .read_empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AFULL_LVL(3), .AEMPTY_LVL(1)) u_fwft (
    .clk(clk), .rst(f_rst), .write_ena(f_we), .write_data(f_wd), .write_full(f_full),
    .read_ena(f_re), .read_data(f_rdata), .read_valid(f_rv), .read_empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic [2:0] cnt;
    logic [6:0] flags;   // {full, empty, afull, aempty, overflow, underflow, read_valid}
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sq[$];
  int         m_count = 0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [7:0] d, input logic r,
                     input logic [2:0] c, input logic [6:0] f);
    vec_t v;
    v.wr = w; v.wd = d; v.rd = r; v.cnt = c; v.flags = f;
    vecs.push_back(v);
  endtask

  function automatic logic [6:0] sflags();
    return {s_full, s_empty, s_af, s_ae, s_ovf, s_unf, s_rv};
  endfunction

  // One clock on the standard instance; the scoreboard tracks accepted writes/reads.
  task automatic step_s(input logic r, input logic w, input logic [7:0] d, input logic rd);
    logic wacc, racc;
    s_rst = r; s_we = w; s_wd = d; s_re = rd;
    wacc = w && (m_count < 4);
    racc = rd && (m_count > 0);
    if (r) begin
      m_count = 0;
      sq.delete();
    end else begin
      if (wacc) sq.push_back(d);
      m_count = m_count + int'(wacc) - int'(racc);
    end
    @(posedge clk);
    #1;
    if (!r && s_rv) begin
      if (sq.size() == 0) chk("std_sb_empty", 32'(s_rdata), 32'hDEAD);
      else chk("std_rdata", 32'(s_rdata), 32'(sq.pop_front()));
    end
  endtask

  task automatic step_f(input logic r, input logic w, input logic [7:0] d, input logic rd);
    f_rst = r; f_we = w; f_wd = d; f_re = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_rst = 1'b1; s_we = 1'b0; s_wd = '0; s_re = 1'b0;
    f_rst = 1'b1; f_we = 1'b0; f_wd = '0; f_re = 1'b0;
    @(posedge clk);
    #1;
    chk("std_rst_count", 32'(s_count), 32'd0);
    chk("std_rst_flags", 32'(sflags()), 32'(7'b0101000));
    chk("std_rst_rdata", 32'(s_rdata), 32'd0);
    chk("fwft_rst_count", 32'(f_count), 32'd0);
    chk("fwft_rst_state", 32'({f_rv, f_empty, f_full, f_af, f_ae, f_ovf, f_unf}), 32'(7'b0100100));

    // fill, overflow, drain, underflow with simultaneous write, then wrap traffic
    add(1, 8'h11, 0, 3'd1, 7'b0001000);
    add(1, 8'h22, 0, 3'd2, 7'b0000000);
    add(1, 8'h33, 0, 3'd3, 7'b0010000);
    add(1, 8'h44, 0, 3'd4, 7'b1010000);
    add(1, 8'h55, 0, 3'd4, 7'b1010100);
    add(0, 8'h00, 1, 3'd3, 7'b0010101);
    add(0, 8'h00, 1, 3'd2, 7'b0000101);
    add(0, 8'h00, 1, 3'd1, 7'b0001101);
    add(0, 8'h00, 1, 3'd0, 7'b0101101);
    add(0, 8'h00, 0, 3'd0, 7'b0101100);
    add(1, 8'hAA, 1, 3'd1, 7'b0001110);
    add(0, 8'h00, 1, 3'd0, 7'b0101111);
    add(1, 8'h01, 0, 3'd1, 7'b0001110);
    add(1, 8'h02, 0, 3'd2, 7'b0000110);
    for (int k = 0; k < 10; k++) add(1, 8'(k + 3), 1, 3'd2, 7'b0000111);
    add(0, 8'h00, 1, 3'd1, 7'b0001111);
    add(0, 8'h00, 1, 3'd0, 7'b0101111);
    add(0, 8'h00, 0, 3'd0, 7'b0101110);

    s_rst = 1'b0;
    foreach (vecs[i]) begin
      step_s(0, vecs[i].wr, vecs[i].wd, vecs[i].rd);
      $display("std vec %0d: wr=%0d wd=%02h rd=%0d -> count=%0d flags=%07b rdata=%02h",
               i, vecs[i].wr, vecs[i].wd, vecs[i].rd, s_count, sflags(), s_rdata);
      chk($sformatf("std_count[%0d]", i), 32'(s_count), 32'(vecs[i].cnt));
      chk($sformatf("std_flags[%0d]", i), 32'(sflags()), 32'(vecs[i].flags));
    end

    // reset while holding 3 entries with a read requested
    step_s(0, 1, 8'h61, 0);
    step_s(0, 1, 8'h62, 0);
    step_s(0, 1, 8'h63, 0);
    chk("std_pre_rst_count", 32'(s_count), 32'd3);
    step_s(1, 0, 8'h00, 1);
    $display("std mid reset: count=%0d flags=%07b", s_count, sflags());
    chk("std_midrst_count", 32'(s_count), 32'd0);
    chk("std_midrst_flags", 32'(sflags()), 32'(7'b0101000));
    chk("std_midrst_rdata", 32'(s_rdata), 32'd0);
    step_s(0, 1, 8'h77, 0);
    chk("std_post_rst_count", 32'(s_count), 32'd1);
    step_s(0, 0, 8'h00, 1);
    $display("std post reset read: rv=%0d rdata=%02h", s_rv, s_rdata);
    chk("std_post_rst_rv", 32'(s_rv), 32'd1);
    chk("std_sb_drained", 32'(sq.size()), 32'd0);

    // FWFT: first word appears two edges after its write edge
    f_rst = 1'b0;
    step_f(0, 1, 8'h5A, 0);
    chk("fwft_w0_rv", 32'(f_rv), 32'd0);
    chk("fwft_w0_count", 32'(f_count), 32'd1);
    step_f(0, 0, 8'h00, 0);
    chk("fwft_w1_rv", 32'(f_rv), 32'd0);
    step_f(0, 0, 8'h00, 0);
    $display("fwft first word: rv=%0d rdata=%02h", f_rv, f_rdata);
    chk("fwft_w2_rv", 32'(f_rv), 32'd1);
    chk("fwft_w2_data", 32'(f_rdata), 32'h5A);
    chk("fwft_w2_empty", 32'(f_empty), 32'd0);
    step_f(0, 1, 8'h5B, 0);
    step_f(0, 1, 8'h5C, 0);
    chk("fwft_count3", 32'(f_count), 32'd3);
    chk("fwft_head_hold", 32'(f_rdata), 32'h5A);
    step_f(0, 0, 8'h00, 1);
    $display("fwft pop: rv=%0d rdata=%02h count=%0d", f_rv, f_rdata, f_count);
    chk("fwft_pop1_data", 32'(f_rdata), 32'h5B);
    chk("fwft_pop1_rv", 32'(f_rv), 32'd1);
    step_f(0, 0, 8'h00, 1);
    $display("fwft pop: rv=%0d rdata=%02h count=%0d", f_rv, f_rdata, f_count);
    chk("fwft_pop2_data", 32'(f_rdata), 32'h5C);
    chk("fwft_pop2_count", 32'(f_count), 32'd1);
    step_f(0, 0, 8'h00, 1);
    $display("fwft pop: rv=%0d rdata=%02h count=%0d", f_rv, f_rdata, f_count);
    chk("fwft_pop3_rv", 32'(f_rv), 32'd0);
    chk("fwft_pop3_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop3_unf", 32'(f_unf), 32'd0);
    step_f(0, 0, 8'h00, 1);
    chk("fwft_unf", 32'(f_unf), 32'd1);

    // FWFT fill to full, overflow attempt, then drain in order
    for (int k = 1; k <= 4; k++) begin
      step_f(0, 1, 8'(k), 0);
      $display("fwft fill: wd=%02h count=%0d full=%0d", 8'(k), f_count, f_full);
      chk($sformatf("fwft_fill_count[%0d]", k), 32'(f_count), 32'(k));
    end
    chk("fwft_full", 32'(f_full), 32'd1);
    chk("fwft_afull", 32'(f_af), 32'd1);
    step_f(0, 1, 8'h05, 0);
    chk("fwft_ovf", 32'(f_ovf), 32'd1);
    chk("fwft_ovf_count", 32'(f_count), 32'd4);
    chk("fwft_head01", 32'(f_rdata), 32'h01);
    for (int k = 2; k <= 4; k++) begin
      step_f(0, 0, 8'h00, 1);
      $display("fwft drain: rv=%0d rdata=%02h count=%0d", f_rv, f_rdata, f_count);
      chk($sformatf("fwft_drain[%0d]", k), 32'(f_rdata), 32'(k));
    end
    step_f(0, 0, 8'h00, 1);
    chk("fwft_drain_end", 32'({f_rv, f_count}), 32'd0);
    f_re = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
